// File: rtl/matrix_read_arbiter_if.sv
// Requester-side bus of matrix_read_arbiter: per-channel request/grant, coordinates,
// returned operand pairs and read-valid pulses, packed with channel i in slice i.
interface matrix_read_arbiter_if #(
   parameter int unsigned maxWidthLen = 4,
   parameter int unsigned sizeValue   = 16,
   parameter int unsigned CHANNELS    = 5
);
   logic [CHANNELS-1:0]             req;
   logic [CHANNELS*maxWidthLen-1:0] rx1;
   logic [CHANNELS*maxWidthLen-1:0] ry1;
   logic [CHANNELS*maxWidthLen-1:0] rx2;
   logic [CHANNELS*maxWidthLen-1:0] ry2;
   logic [CHANNELS-1:0]             gnt;
   logic [CHANNELS*sizeValue-1:0]   out1;
   logic [CHANNELS*sizeValue-1:0]   out2;
   logic [CHANNELS-1:0]             rvalid;
   logic                            busy;

   modport master (
      output req, rx1, ry1, rx2, ry2,
      input  gnt, out1, out2, rvalid, busy
   );

   modport slave (
      input  req, rx1, ry1, rx2, ry2,
      output gnt, out1, out2, rvalid, busy
   );
endinterface

// File: rtl/matrix_read_arbiter.sv
// Round-robin arbiter sharing the matrix store's dual read port among CHANNELS requesters,
// with a READ_LAT-deep tag pipeline routing returned data. Define MATRIX_ARB_FIXED_PRIO_EN for fixed priority.
module matrix_read_arbiter #(
   parameter int unsigned maxWidthLen = 4,
   parameter int unsigned sizeValue   = 16,
   parameter int unsigned CHANNELS    = 5,
   parameter int unsigned READ_LAT    = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   matrix_read_arbiter_if.slave        bus,
   output logic [maxWidthLen-1:0]      rx1matrix,
   output logic [maxWidthLen-1:0]      ry1matrix,
   output logic [maxWidthLen-1:0]      rx2matrix,
   output logic [maxWidthLen-1:0]      ry2matrix,
   input  logic signed [sizeValue-1:0] out1matrix,
   input  logic signed [sizeValue-1:0] out2matrix
);
   localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned LAST  = READ_LAT - 1;
   localparam int unsigned OUT_W = CHANNELS * sizeValue;

   logic                           gnt_vld_c;
   logic [CH_W-1:0]                gnt_idx_c;
   logic [READ_LAT-1:0]            tag_vld_q, tag_vld_d;
   logic [READ_LAT-1:0][CH_W-1:0]  tag_ch_q, tag_ch_d;
   logic [OUT_W-1:0]               out1_q, out1_d;
   logic [OUT_W-1:0]               out2_q, out2_d;
   logic [CHANNELS-1:0]            rvalid_q, rvalid_d;
   logic                           busy_q, busy_d;
`ifndef MATRIX_ARB_FIXED_PRIO_EN
   logic [CH_W-1:0]                ptr_q, ptr_d;
   logic [CH_W:0]                  cand_c;
`endif

   // Arbitration: pick the winning channel index
   always_comb begin
      gnt_vld_c = 1'b0;
      gnt_idx_c = '0;
`ifdef MATRIX_ARB_FIXED_PRIO_EN
      // Descending scan so the lowest active index is the last (winning) write
      for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
         if (bus.req[i]) begin
            gnt_vld_c = 1'b1;
            gnt_idx_c = CH_W'(i);
         end
      end
`else
      cand_c = '0;
      ptr_d  = ptr_q;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         cand_c = (CH_W+1)'(ptr_q) + (CH_W+1)'(i);
         if (cand_c >= (CH_W+1)'(CHANNELS)) begin
            cand_c = cand_c - (CH_W+1)'(CHANNELS);
         end
         if (!gnt_vld_c && bus.req[cand_c[CH_W-1:0]]) begin
            gnt_vld_c = 1'b1;
            gnt_idx_c = cand_c[CH_W-1:0];
         end
      end
      if (gnt_vld_c) begin
         ptr_d = (gnt_idx_c == CH_W'(CHANNELS - 1)) ? '0 : gnt_idx_c + CH_W'(1);
      end
`endif
   end

   // Grant decode and storage address mux
   always_comb begin
      bus.gnt   = '0;
      rx1matrix = '0;
      ry1matrix = '0;
      rx2matrix = '0;
      ry2matrix = '0;
      if (gnt_vld_c) begin
         bus.gnt[gnt_idx_c] = 1'b1;
         rx1matrix = bus.rx1[int'(gnt_idx_c)*maxWidthLen +: maxWidthLen];
         ry1matrix = bus.ry1[int'(gnt_idx_c)*maxWidthLen +: maxWidthLen];
         rx2matrix = bus.rx2[int'(gnt_idx_c)*maxWidthLen +: maxWidthLen];
         ry2matrix = bus.ry2[int'(gnt_idx_c)*maxWidthLen +: maxWidthLen];
      end
   end

   // Tag shift and return-data steering; the final stage coincides with the rvalid cycle
   always_comb begin
      tag_vld_d    = '0;
      tag_ch_d     = '0;
      tag_vld_d[0] = gnt_vld_c;
      tag_ch_d[0]  = gnt_idx_c;
      for (int k = 1; k < int'(READ_LAT); k++) begin
         tag_vld_d[k] = tag_vld_q[k-1];
         tag_ch_d[k]  = tag_ch_q[k-1];
      end
      out1_d   = out1_q;
      out2_d   = out2_q;
      rvalid_d = '0;
      if (tag_vld_d[LAST]) begin
         rvalid_d[tag_ch_d[LAST]] = 1'b1;
         out1_d[int'(tag_ch_d[LAST])*sizeValue +: sizeValue] = out1matrix;
         out2_d[int'(tag_ch_d[LAST])*sizeValue +: sizeValue] = out2matrix;
      end
      busy_d = |tag_vld_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld_q <= '0;
         tag_ch_q  <= '0;
         out1_q    <= '0;
         out2_q    <= '0;
         rvalid_q  <= '0;
         busy_q    <= 1'b0;
`ifndef MATRIX_ARB_FIXED_PRIO_EN
         ptr_q     <= '0;
`endif
      end else begin
         tag_vld_q <= tag_vld_d;
         tag_ch_q  <= tag_ch_d;
         out1_q    <= out1_d;
         out2_q    <= out2_d;
         rvalid_q  <= rvalid_d;
         busy_q    <= busy_d;
`ifndef MATRIX_ARB_FIXED_PRIO_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   assign bus.out1   = out1_q;
   assign bus.out2   = out2_q;
   assign bus.rvalid = rvalid_q;
   assign bus.busy   = busy_q;
endmodule

// File: tb/tb_matrix_read_arbiter.sv
// Directed bench for matrix_read_arbiter: three instances (READ_LAT 1, 2, 3) share one
// requester stimulus; each has its own storage model with the matching read latency.
module tb_matrix_read_arbiter;
   localparam int unsigned CH = 5;

   typedef struct packed {
      logic [CH-1:0] req;
      logic [CH-1:0] gnt;
   } vec_t;

   logic clk;
   logic rst_n;
   logic [CH-1:0]   req_v;
   logic [CH*4-1:0] rx1_v, ry1_v, rx2_v, ry2_v;

   logic [3:0] cx1 [CH] = '{4'd1, 4'd5, 4'd3, 4'd7, 4'd9};
   logic [3:0] cy1 [CH] = '{4'd2, 4'd4, 4'd1, 4'd0, 4'd15};
   logic [3:0] cx2 [CH] = '{4'd0, 4'd2, 4'd0, 4'd6, 4'd8};
   logic [3:0] cy2 [CH] = '{4'd3, 4'd3, 4'd2, 4'd1, 4'd14};

   int n_vec;
   int n_err;
   logic [CH*16-1:0] eo1, eo2, e3o1, e3o2;
   logic [CH-1:0]    er;
   vec_t             tbl [16];

   matrix_read_arbiter_if #(.maxWidthLen(4), .sizeValue(16), .CHANNELS(CH)) if1 ();
   matrix_read_arbiter_if #(.maxWidthLen(4), .sizeValue(16), .CHANNELS(CH)) if2 ();
   matrix_read_arbiter_if #(.maxWidthLen(4), .sizeValue(16), .CHANNELS(CH)) if3 ();

   assign if1.req = req_v; assign if1.rx1 = rx1_v; assign if1.ry1 = ry1_v;
   assign if1.rx2 = rx2_v; assign if1.ry2 = ry2_v;
   assign if2.req = req_v; assign if2.rx1 = rx1_v; assign if2.ry1 = ry1_v;
   assign if2.rx2 = rx2_v; assign if2.ry2 = ry2_v;
   assign if3.req = req_v; assign if3.rx1 = rx1_v; assign if3.ry1 = ry1_v;
   assign if3.rx2 = rx2_v; assign if3.ry2 = ry2_v;

   logic [3:0] m1x1, m1y1, m1x2, m1y2, m2x1, m2y1, m2x2, m2y2, m3x1, m3y1, m3x2, m3y2;
   logic signed [15:0] s1_l1, s2_l1, s1_l2, s2_l2, s1_l3, s2_l3;
   logic signed [15:0] p3a_1, p3a_2;

   function automatic logic signed [15:0] d1(input logic [3:0] x, input logic [3:0] y);
      return 16'({x, y}) - 16'd56;
   endfunction

   function automatic logic signed [15:0] d2(input logic [3:0] x, input logic [3:0] y);
      return 16'({x, y}) + 16'd10;
   endfunction

   function automatic logic [15:0] exp_mat(input logic [CH-1:0] g);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < int'(CH); i++) if (g[i]) r = {cx1[i], cy1[i], cx2[i], cy2[i]};
      return r;
   endfunction

   // Storage models: data valid READ_LAT-1 cycles after the address
   assign s1_l1 = d1(m1x1, m1y1);
   assign s2_l1 = d2(m1x2, m1y2);
   always @(posedge clk) begin
      s1_l2 <= d1(m2x1, m2y1);
      s2_l2 <= d2(m2x2, m2y2);
      p3a_1 <= d1(m3x1, m3y1);
      p3a_2 <= d2(m3x2, m3y2);
      s1_l3 <= p3a_1;
      s2_l3 <= p3a_2;
   end

   matrix_read_arbiter #(.maxWidthLen(4), .sizeValue(16), .CHANNELS(CH), .READ_LAT(1)) u_l1 (
      .clk(clk), .rst_n(rst_n), .bus(if1.slave),
      .rx1matrix(m1x1), .ry1matrix(m1y1), .rx2matrix(m1x2), .ry2matrix(m1y2),
      .out1matrix(s1_l1), .out2matrix(s2_l1));

   matrix_read_arbiter #(.maxWidthLen(4), .sizeValue(16), .CHANNELS(CH), .READ_LAT(2)) u_l2 (
      .clk(clk), .rst_n(rst_n), .bus(if2.slave),
      .rx1matrix(m2x1), .ry1matrix(m2y1), .rx2matrix(m2x2), .ry2matrix(m2y2),
      .out1matrix(s1_l2), .out2matrix(s2_l2));

   matrix_read_arbiter #(.maxWidthLen(4), .sizeValue(16), .CHANNELS(CH), .READ_LAT(3)) u_l3 (
      .clk(clk), .rst_n(rst_n), .bus(if3.slave),
      .rx1matrix(m3x1), .ry1matrix(m3y1), .rx2matrix(m3x2), .ry2matrix(m3y2),
      .out1matrix(s1_l3), .out2matrix(s2_l3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_v = '0;
      rst_n = 1'b0;
      eo1 = '0; eo2 = '0; e3o1 = '0; e3o2 = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic upd1(input int k);
      eo1[k*16 +: 16] = d1(cx1[k], cy1[k]);
      eo2[k*16 +: 16] = d2(cx2[k], cy2[k]);
   endtask

   task automatic upd3(input int k);
      e3o1[k*16 +: 16] = d1(cx1[k], cy1[k]);
      e3o2[k*16 +: 16] = d2(cx2[k], cy2[k]);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      req_v = '0;
      for (int i = 0; i < int'(CH); i++) begin
         rx1_v[i*4 +: 4] = cx1[i]; ry1_v[i*4 +: 4] = cy1[i];
         rx2_v[i*4 +: 4] = cx2[i]; ry2_v[i*4 +: 4] = cy2[i];
      end
      // Round-robin sequence from ptr=0, hand-computed grants
      tbl[0]  = '{5'b11111, 5'b00001};
      tbl[1]  = '{5'b11111, 5'b00010};
      tbl[2]  = '{5'b11111, 5'b00100};
      tbl[3]  = '{5'b11111, 5'b01000};
      tbl[4]  = '{5'b11111, 5'b10000};
      tbl[5]  = '{5'b11111, 5'b00001};
      tbl[6]  = '{5'b00100, 5'b00100};
      tbl[7]  = '{5'b11111, 5'b01000};
      tbl[8]  = '{5'b00000, 5'b00000};
      tbl[9]  = '{5'b00001, 5'b00001};
      tbl[10] = '{5'b10001, 5'b10000};
      tbl[11] = '{5'b10001, 5'b00001};
      tbl[12] = '{5'b00110, 5'b00010};
      tbl[13] = '{5'b01001, 5'b01000};
      tbl[14] = '{5'b00011, 5'b00001};
      tbl[15] = '{5'b00000, 5'b00000};

      // Reset state and single read on channel 2
      do_reset();
      chk("rst_gnt", 128'(if1.gnt), 128'(5'b0));
      chk("rst_rvalid", 128'(if1.rvalid), 128'(5'b0));
      chk("rst_busy", 128'(if1.busy), 128'(1'b0));
      chk("rst_out1", 128'(if1.out1), 128'(80'h0));
      chk("rst_out2", 128'(if1.out2), 128'(80'h0));
      req_v = 5'b00100;
      #1;
      chk("c2_gnt", 128'(if1.gnt), 128'(5'b00100));
      chk("c2_mat", 128'({m1x1, m1y1, m1x2, m1y2}), 128'(16'h3102));
      tick();
      req_v = '0;
      chk("c2_rvalid", 128'(if1.rvalid), 128'(5'b00100));
      chk("c2_out1", 128'(if1.out1), 128'(80'h0000_0000_FFF9_0000_0000));
      chk("c2_out2", 128'(if1.out2), 128'(80'h0000_0000_000C_0000_0000));
      tick();
      chk("c2_rvalid_end", 128'(if1.rvalid), 128'(5'b0));
      chk("c2_out1_held", 128'(if1.out1), 128'(80'h0000_0000_FFF9_0000_0000));

      // Table-driven round-robin vectors on READ_LAT=1
      do_reset();
      for (int i = 0; i < 16; i++) begin
         req_v = tbl[i].req;
         #1;
         chk($sformatf("v%0d_gnt", i), 128'(if1.gnt), 128'(tbl[i].gnt));
         chk($sformatf("v%0d_mat", i), 128'({m1x1, m1y1, m1x2, m1y2}), 128'(exp_mat(tbl[i].gnt)));
         tick();
         for (int k = 0; k < int'(CH); k++) if (tbl[i].gnt[k]) upd1(k);
         chk($sformatf("v%0d_rvalid", i), 128'(if1.rvalid), 128'(tbl[i].gnt));
         chk($sformatf("v%0d_busy", i), 128'(if1.busy), 128'(tbl[i].gnt != '0));
         chk($sformatf("v%0d_out1", i), 128'(if1.out1), 128'(eo1));
         chk($sformatf("v%0d_out2", i), 128'(if1.out2), 128'(eo2));
      end

      // Idle for 10 cycles: outputs quiet, data held
      req_v = '0;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("idle_gnt", 128'(if1.gnt), 128'(5'b0));
         chk("idle_mat", 128'({m1x1, m1y1, m1x2, m1y2}), 128'(16'h0));
         tick();
         chk("idle_rvalid", 128'(if1.rvalid), 128'(5'b0));
         chk("idle_out1", 128'(if1.out1), 128'(eo1));
         chk("idle_out2", 128'(if1.out2), 128'(eo2));
      end

      // Channel 4 withdraws its request before being granted
      do_reset();
      req_v = 5'b10001;
      #1;
      chk("drop_gnt", 128'(if1.gnt), 128'(5'b00001));
      tick();
      req_v = '0;
      chk("drop_rv0", 128'(if1.rvalid), 128'(5'b00001));
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("drop_rv4", 128'(if1.rvalid), 128'(5'b0));
      end

      // READ_LAT=3: grants 1,3,1 back to back
      do_reset();
      req_v = 5'b00010;
      #1;
      chk("l3_gnt_a", 128'(if3.gnt), 128'(5'b00010));
      tick();
      req_v = 5'b01000;
      #1;
      chk("l3_gnt_b", 128'(if3.gnt), 128'(5'b01000));
      chk("l3_busy_1", 128'(if3.busy), 128'(1'b1));
      tick();
      req_v = 5'b00010;
      #1;
      chk("l3_gnt_c", 128'(if3.gnt), 128'(5'b00010));
      chk("l3_busy_2", 128'(if3.busy), 128'(1'b1));
      tick();
      req_v = '0;
      for (int c = 3; c <= 7; c++) begin
         er = (c == 3 || c == 5) ? 5'b00010 : (c == 4) ? 5'b01000 : 5'b00000;
         for (int k = 0; k < int'(CH); k++) if (er[k]) upd3(k);
         chk($sformatf("l3_c%0d_rvalid", c), 128'(if3.rvalid), 128'(er));
         chk($sformatf("l3_c%0d_busy", c), 128'(if3.busy), 128'(c <= 5));
         chk($sformatf("l3_c%0d_out1", c), 128'(if3.out1), 128'(e3o1));
         chk($sformatf("l3_c%0d_out2", c), 128'(if3.out2), 128'(e3o2));
         tick();
      end

      // READ_LAT=2: reset lands with two reads in flight
      do_reset();
      req_v = 5'b00010;
      tick();
      req_v = 5'b00100;
      tick();
      req_v = '0;
      rst_n = 1'b0;
      #1;
      chk("mr_busy_in_rst", 128'(if2.busy), 128'(1'b0));
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mr_rvalid", 128'(if2.rvalid), 128'(5'b0));
         chk("mr_busy", 128'(if2.busy), 128'(1'b0));
         chk("mr_out1", 128'(if2.out1), 128'(80'h0));
         chk("mr_out2", 128'(if2.out2), 128'(80'h0));
      end
      req_v = 5'b11111;
      #1;
      chk("mr_ptr0", 128'(if2.gnt), 128'(5'b00001));
      tick();
      req_v = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
